// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM encoding, counter sizing and
// the default word width used by both the transmit and receive sides.
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int SER_DEFAULT_WIDTH = 4;

   // Bits needed to count the positions of a WIDTH-bit word, ceil(log2(WIDTH)).
   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer_4bit_if.sv
// Load handshake and serial output bundle of the PISO serializer.
//
// Handshake: a word moves on a rising clock edge where load_valid and
// load_ready are both high. load_ready never looks at load_valid, so a
// source may raise load_valid whenever it likes but must hold load_data
// stable until the transfer edge. sout/sof/eof are meaningful only while
// sout_valid is high.
interface piso_serializer_4bit_if
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_DEFAULT_WIDTH
);

   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             sof;
   logic             eof;
   logic             busy;

   modport master (
      output load_data, load_valid,
      input  load_ready, sout, sout_valid, sof, eof, busy
   );

   modport slave (
      input  load_data, load_valid,
      output load_ready, sout, sout_valid, sof, eof, busy
   );

endinterface

// File: rtl/piso_serializer_4bit.sv
// Parallel-in serial-out transmitter. Accepts a word over load_valid/ready
// and shifts it out MSB first with sof/eof frame markers. A new word can be
// taken on the last bit of the current frame, so frames run back to back.
module piso_serializer_4bit
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_DEFAULT_WIDTH
)(
   input  logic   clock,
   input  logic   clear,
   piso_serializer_4bit_if.slave bus,
   output state_t dbg_state
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             last_bit;
   logic             accept;

   assign last_bit = (state == SHIFT) && (cnt == LAST);
   // Ready depends on registered state only, never on load_valid.
   assign accept   = bus.load_valid && bus.load_ready;

   // Register state, shift register and bit counter; clear aborts any frame.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: a load on the last bit wins over returning to IDLE.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      if (accept) begin
         state_nxt = SHIFT;
         shreg_nxt = bus.load_data;
         cnt_nxt   = '0;
      end else if (state == SHIFT) begin
         // Zeros enter at the LSB so sout idles low once the frame drains.
         shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
         if (cnt == LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   assign bus.load_ready = (state == IDLE) || last_bit;
   assign bus.sout       = shreg[WIDTH-1];
   assign bus.sout_valid = (state == SHIFT);
   assign bus.busy       = (state == SHIFT);
   assign bus.sof        = (state == SHIFT) && (cnt == '0);
   assign bus.eof        = last_bit;
   assign dbg_state      = state;

endmodule

// File: tb/tb_piso_serializer_4bit.sv
// Bench for piso_serializer_4bit: directed words go in through a driver,
// expected {sout,sof,eof} triples are queued per accepted word and a
// negedge monitor pops and compares them whenever sout_valid is high.
module tb_piso_serializer_4bit;
   import serial_pkg::*;

   localparam int W = 4;

   logic   clock;
   logic   clear;
   state_t dbg_state;

   piso_serializer_4bit_if #(.WIDTH(W)) bus ();

   piso_serializer_4bit #(.WIDTH(W)) dut (
      .clock     (clock),
      .clear     (clear),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q[$];
   logic       mon_on = 1'b0;
   int         run_len = 0;
   int         last_run = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare each frame bit against the queue; idle outputs must be low.
   always @(negedge clock) begin
      if (mon_on) begin
         if (bus.sout_valid === 1'b1) begin
            run_len = run_len + 1;
            if (exp_q.size() == 0) begin
               chk("unexpected_bit", 32'(bus.sout_valid), 32'd0);
            end else begin
               chk("frame_bit", 32'({bus.sout, bus.sof, bus.eof}), 32'(exp_q.pop_front()));
               chk("busy_hi", 32'(bus.busy), 32'd1);
            end
         end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            chk("idle_outs", 32'({bus.sout, bus.sof, bus.eof, bus.busy}), 32'd0);
         end
      end
   end

   // Four-stage serial-in register fed by the link for the loopback test.
   logic [W-1:0] sipo;
   always @(posedge clock) begin
      if (bus.sout_valid) sipo <= {sipo[W-2:0], bus.sout};
   end

   // ---------------- driver tasks ----------------
   task automatic push_frame(input logic [W-1:0] word);
      for (int k = W - 1; k >= 0; k--) begin
         exp_q.push_back({word[k], (k == W - 1), (k == 0)});
      end
   endtask

   // Present a word, wait for ready, return number of stalled cycles.
   task automatic send(input logic [W-1:0] word, output int waits);
      bus.load_data  = word;
      bus.load_valid = 1'b1;
      waits = 0;
      @(negedge clock);
      while (bus.load_ready !== 1'b1 && waits < 50) begin
         waits++;
         @(negedge clock);
      end
      if (bus.load_ready !== 1'b1) chk("ready_timeout", 32'(bus.load_ready), 32'd1);
      push_frame(word);
      @(posedge clock);
      #1;
      bus.load_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clock);
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clock);
      end
      chk("idle_timeout", 32'(bus.busy), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w1, w2;
      clear          = 1'b0;
      bus.load_data  = '0;
      bus.load_valid = 1'b0;

      // Reset asserted mid-clock: outputs drop without any clock edge.
      #7;
      clear = 1'b1;
      #1;
      chk("rst_outs", 32'({bus.sout, bus.sout_valid, bus.sof, bus.eof, bus.busy}), 32'd0);
      chk("rst_ready", 32'(bus.load_ready), 32'd1);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      mon_on = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("idle_sout", 32'({bus.sout, bus.sout_valid}), 32'd0);
      end

      // Single word 1011 from IDLE: no stall, 1,0,1,1 out.
      @(posedge clock); #1;
      send(4'b1011, w1);
      chk("single_wait", 32'(w1), 32'd0);
      wait_idle();
      chk("single_sout_idle", 32'(bus.sout), 32'd0);

      // Back to back 1100 then 0011: second taken on eof, 8-bit run without gap.
      @(posedge clock); #1;
      send(4'b1100, w1);
      send(4'b0011, w2);
      chk("b2b_wait", 32'(w2), 32'd3);
      wait_idle();
      @(negedge clock);
      chk("b2b_run", 32'(last_run), 32'd8);

      // Backpressure: 0110 offered on cycle 2 of a 1111 frame waits 2 cycles.
      @(posedge clock); #1;
      send(4'b1111, w1);
      @(posedge clock); #1;
      send(4'b0110, w2);
      chk("bp_wait", 32'(w2), 32'd2);
      wait_idle();
      @(negedge clock);
      chk("bp_run", 32'(last_run), 32'd8);

      // Mid-frame clear after two bits of 1001 aborts the rest.
      @(posedge clock); #1;
      send(4'b1001, w1);
      @(negedge clock);
      @(negedge clock);
      #2;
      clear = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_clr_outs", 32'({bus.sout, bus.sout_valid, bus.sof, bus.eof, bus.busy}), 32'd0);
      chk("mid_clr_ready", 32'(bus.load_ready), 32'd1);
      repeat (2) @(negedge clock);
      #1;
      clear = 1'b0;
      repeat (4) @(negedge clock);
      chk("mid_clr_quiet", 32'(bus.sout_valid), 32'd0);
      @(posedge clock); #1;
      send(4'b0101, w1);
      chk("post_clr_wait", 32'(w1), 32'd0);
      wait_idle();

      // Loopback into the serial-in register for every 4-bit value.
      for (int v = 0; v < 16; v++) begin
         @(posedge clock); #1;
         send(W'(v), w1);
         wait_idle();
         chk("loopback", 32'(sipo), 32'(v));
      end

      repeat (3) @(negedge clock);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
